// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction-fetch stage.
package fetch_pkg;

   localparam int              XLEN        = 32;
   localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
   localparam int              INSTR_BYTES = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable FIFO of PC-tagged instructions; the head is read straight from the
// entry registers so decode sees it in the same cycle it becomes valid.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_entry_t           wdata,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset: occupancy alone decides what is valid.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (push && !flush && (wr_ptr_q == AW'(gi))) begin
            mem_q[gi] <= wdata;
         end
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency imem reads and
// queues PC-tagged instructions for decode behind a valid/ready handshake.
module fetch_unit
#(
   parameter int              XLEN       = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   import fetch_pkg::*;

   localparam int              AW         = $clog2(FIFO_DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
   localparam logic [AW:0]     DEPTH_W    = (AW+1)'(FIFO_DEPTH);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic            inflight_q;
   logic            kill_q;

   logic            pop;
   logic            push;
   logic            issue;
   logic [AW:0]     fifo_count;
   logic [AW:0]     occupancy;
   logic [AW:0]     budget;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   assign pop  = !fifo_empty && instr_ready && !redirect_valid;
   assign push = inflight_q && !kill_q && !redirect_valid && (state_q == ST_RUN);

   // Entries already queued plus the one in flight must leave room after this
   // cycle's pop, so every issued read is guaranteed a slot when it returns.
   assign occupancy = fifo_count + (AW+1)'(inflight_q);
   assign budget    = DEPTH_W + (AW+1)'(pop);
   assign issue     = rst && !redirect_valid && (occupancy < budget);

   assign imem_req  = issue;
   assign imem_addr = pc_q & ALIGN_MASK;

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         pc_d      = pc_q + PC_STEP;
         resp_pc_d = pc_q & ALIGN_MASK;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC & ALIGN_MASK;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= ST_RUN;
            default: state_q <= ST_RUN;
         endcase
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= issue;
         kill_q     <= redirect_valid && inflight_q;
      end
   end

   assign push_entry.pc    = resp_pc_q;
   assign push_entry.instr = imem_rdata;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .flush (redirect_valid),
      .count (fifo_count),
      .head  (head_entry),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign instr_valid = !fifo_empty;
   assign instr       = fifo_empty ? '0 : head_entry.instr;
   assign instr_pc    = fifo_empty ? '0 : head_entry.pc;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table for the directed scenarios,
// an asynchronous mid-stream reset, then random traffic against a stream model.
module tb_fetch_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;

   fetch_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // Instruction memory: data for a request appears one cycle later; garbage otherwise.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ins;
      logic [31:0] ipc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] ipc);
      vec_t v;
      v.rdy   = rdy;
      v.redir = redir;
      v.rpc   = rpc;
      v.req   = req;
      v.addr  = addr;
      v.vld   = vld;
      v.ipc   = ipc;
      v.ins   = mem_word(ipc);
      return v;
   endfunction

   initial begin
      int          since;
      int          issued;
      int          delivered;
      logic [31:0] exp_issue;
      logic [31:0] exp_del;
      logic        exp_vld;
      logic        exp_req;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;

      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      repeat (2) @(negedge clk);
      check("reset.instr_valid", 32'(instr_valid), 32'd0);
      check("reset.imem_req", 32'(imem_req), 32'd0);
      check("reset.instr", instr, 32'd0);
      check("reset.instr_pc", instr_pc, 32'd0);

      // One row per cycle, starting with the half cycle after reset release.
      //                 rdy   redir rpc            req   addr           vld   instr_pc
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h4));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'h8));
      tbl.push_back(mk(1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b1, 32'hC));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h100));
      tbl.push_back(mk(1'b1, 1'b1, 32'h203,       1'b0, 32'h0,         1'b1, 32'h104));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h204,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h208,       1'b1, 32'h200));
      tbl.push_back(mk(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 32'h204));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h0));
      tbl.push_back(mk(1'b1, 1'b1, 32'h300,       1'b0, 32'h0,         1'b1, 32'h4));
      tbl.push_back(mk(1'b1, 1'b1, 32'h400,       1'b0, 32'h0,         1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h400,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h404,       1'b0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h408,       1'b1, 32'h400));

      rst = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         instr_ready    = tbl[i].rdy;
         redirect_valid = tbl[i].redir;
         redirect_pc    = tbl[i].rpc;
         #1;
         check($sformatf("row%0d.imem_req", i), 32'(imem_req), 32'(tbl[i].req));
         if (tbl[i].req) check($sformatf("row%0d.imem_addr", i), imem_addr, tbl[i].addr);
         check($sformatf("row%0d.instr_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) begin
            check($sformatf("row%0d.instr", i), instr, tbl[i].ins);
            check($sformatf("row%0d.instr_pc", i), instr_pc, tbl[i].ipc);
         end
         $display("row %0d: rdy=%b redir=%b req=%b addr=%h valid=%b instr=%h pc=%h",
                  i, instr_ready, redirect_valid, imem_req, imem_addr, instr_valid, instr, instr_pc);
         @(negedge clk);
      end

      // Asynchronous reset between clock edges while the stream is busy.
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst.instr_valid", 32'(instr_valid), 32'd0);
      check("async_rst.imem_req", 32'(imem_req), 32'd0);
      check("async_rst.instr", instr, 32'd0);
      check("async_rst.instr_pc", instr_pc, 32'd0);
      $display("async reset: valid=%b req=%b", instr_valid, imem_req);
      repeat (2) @(negedge clk);

      // Random phase: the delivered and requested streams must each count up by 4
      // from the last restart point (reset or redirect), with fixed restart latency.
      rst       = 1'b1;
      since     = 0;
      issued    = 0;
      delivered = 0;
      exp_issue = 32'h0;
      exp_del   = 32'h0;
      for (int c = 0; c < 1500; c++) begin
         rdy   = ($urandom_range(0, 9) < 7);
         redir = (c > 3) && ($urandom_range(0, 24) == 0);
         rpc   = $urandom();
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
         instr_ready    = rdy;
         redirect_valid = redir;
         redirect_pc    = rpc;
         #1;
         exp_vld = (since >= 2);
         exp_req = !redir && ((issued - delivered - ((exp_vld && rdy) ? 1 : 0)) < DEPTH);
         check($sformatf("rnd%0d.instr_valid", c), 32'(instr_valid), 32'(exp_vld));
         check($sformatf("rnd%0d.imem_req", c), 32'(imem_req), 32'(exp_req));
         if (exp_req) check($sformatf("rnd%0d.imem_addr", c), imem_addr, exp_issue);
         if (exp_vld) begin
            check($sformatf("rnd%0d.instr_pc", c), instr_pc, exp_del);
            check($sformatf("rnd%0d.instr", c), instr, mem_word(exp_del));
         end
         if (redir) begin
            $display("cycle %0d: redirect to %h", c, rpc);
            exp_issue = rpc & 32'hFFFF_FFFC;
            exp_del   = rpc & 32'hFFFF_FFFC;
            issued    = 0;
            delivered = 0;
            since     = 0;
         end else begin
            if (exp_req) begin
               exp_issue = exp_issue + 32'd4;
               issued++;
            end
            if (exp_vld && rdy) begin
               $display("cycle %0d: deliver pc=%h instr=%h", c, instr_pc, instr);
               exp_del = exp_del + 32'd4;
               delivered++;
            end
            if (since < 2) since++;
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
